prog_loader: RTL and testbench

- Serial writer for the processor's 12-bit-addressed, 8-bit-wide program store. The fetch path is the reader of the same store.
- Receives framed bytes on a UART line (8N1, LSB first) and issues single-cycle write strobes with address and data.
- Asserts a CPU hold while a frame is in progress, so the core can be kept in reset during download.

---
 rtl/prog_loader.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_prog_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : prog_loader
// Description : UART (8N1, LSB first) serial writer for the program store.
//               Frame: A5, ADDR_HI, ADDR_LO, LEN, LEN data bytes, CHK (XOR of
//               all bytes after SYNC). Each data byte issues a one-cycle write
//               strobe. cpu_hold is high while a frame is in progress.
//               Optional macro PROG_LOADER_TIMEOUT_EN adds an idle timeout
//               that aborts a stalled frame.
// Revision    : 1.0 - initial release
// ============================================================================
module prog_loader #(
  parameter int CLK_DIV = 87,
  parameter int ADDR_W  = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rxd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [11:0] c_half = 12'(CLK_DIV / 2 - 1);
  localparam logic [11:0] c_full = 12'(CLK_DIV - 1);
  localparam logic [7:0]  c_sync = 8'hA5;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  typedef enum logic [2:0] {
    F_SYNC = 3'd0,
    F_AH   = 3'd1,
    F_AL   = 3'd2,
    F_LEN  = 3'd3,
    F_DATA = 3'd4,
    F_CHK  = 3'd5
  } f_state_t;

  // Synchronizer plus one extra stage for falling-edge detection
  logic rxd_s1_q, rxd_s2_q, rxd_prev_q;

  // Receiver state
  rx_state_t   rx_state_q, rx_state_d;
  logic [11:0] cnt_q, cnt_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  byte_q, byte_d;
  logic        bv_q, bv_d;
  logic        ferr_q, ferr_d;

  // Frame state
  f_state_t          f_state_q, f_state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [8:0]        rem_q, rem_d;
  logic [7:0]        chk_q, chk_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              hold_q, hold_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

`ifdef PROG_LOADER_TIMEOUT_EN
  localparam logic [19:0] c_tmo = 20'(16 * CLK_DIV * 10);
  logic [19:0] idle_q, idle_d;
`endif

  // Two-flop synchronizer on the asynchronous receive line
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rxd_s1_q   <= 1'b1;
      rxd_s2_q   <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_s1_q   <= rxd;
      rxd_s2_q   <= rxd_s1_q;
      rxd_prev_q <= rxd_s2_q;
    end
  end

  // Byte receiver next-state: mid-bit sampling, stop bit qualifies the byte
  always_comb begin
    rx_state_d = rx_state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_d     = byte_q;
    bv_d       = 1'b0;
    ferr_d     = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_s2_q) begin
          rx_state_d = RX_START;
          cnt_d      = 12'd0;
        end
      end
      RX_START: begin
        if (cnt_q == c_half) begin
          cnt_d      = 12'd0;
          bit_d      = 3'd0;
          // A high line at mid start bit was a glitch; drop it silently
          rx_state_d = rxd_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      RX_DATA: begin
        if (cnt_q == c_full) begin
          cnt_d   = 12'd0;
          shift_d = {rxd_s2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      RX_STOP: begin
        if (cnt_q == c_full) begin
          cnt_d      = 12'd0;
          rx_state_d = RX_IDLE;
          if (rxd_s2_q) begin
            bv_d   = 1'b1;
            byte_d = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Byte receiver registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= 12'd0;
      bit_q      <= 3'd0;
      shift_q    <= 8'd0;
      byte_q     <= 8'd0;
      bv_q       <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      rx_state_q <= rx_state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      byte_q     <= byte_d;
      bv_q       <= bv_d;
      ferr_q     <= ferr_d;
    end
  end

  // Frame parser next-state; a framing error overrides any byte handling
  always_comb begin
    f_state_d   = f_state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    chk_d       = chk_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hold_d      = hold_q;
    done_d      = 1'b0;
    err_d       = err_q;
`ifdef PROG_LOADER_TIMEOUT_EN
    idle_d = (bv_q || ferr_q || (f_state_q == F_SYNC)) ? 20'd0 : idle_q + 20'd1;
`endif
    if (ferr_q) begin
      f_state_d = F_SYNC;
      err_d     = 1'b1;
      hold_d    = 1'b0;
    end else if (bv_q) begin
      case (f_state_q)
        F_SYNC: begin
          if (byte_q == c_sync) begin
            f_state_d = F_AH;
            hold_d    = 1'b1;
            err_d     = 1'b0;
            chk_d     = 8'd0;
          end
        end
        F_AH: begin
          // Only the low nibble carries address bits; bits 11:8 of the address
          addr_d    = ADDR_W'({byte_q[3:0], 8'h00});
          chk_d     = chk_q ^ byte_q;
          f_state_d = F_AL;
        end
        F_AL: begin
          addr_d    = {addr_q[ADDR_W-1:8], byte_q};
          chk_d     = chk_q ^ byte_q;
          f_state_d = F_LEN;
        end
        F_LEN: begin
          rem_d     = (byte_q == 8'd0) ? 9'd256 : {1'b0, byte_q};
          chk_d     = chk_q ^ byte_q;
          f_state_d = F_DATA;
        end
        F_DATA: begin
          mem_we_d    = 1'b1;
          mem_addr_d  = addr_q;
          mem_wdata_d = byte_q;
          addr_d      = addr_q + 1'b1;
          rem_d       = rem_q - 9'd1;
          chk_d       = chk_q ^ byte_q;
          if (rem_q == 9'd1) begin
            f_state_d = F_CHK;
          end
        end
        F_CHK: begin
          f_state_d = F_SYNC;
          hold_d    = 1'b0;
          if (byte_q == chk_q) begin
            done_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: f_state_d = F_SYNC;
      endcase
`ifdef PROG_LOADER_TIMEOUT_EN
    end else if ((f_state_q != F_SYNC) && (idle_q == c_tmo - 20'd1)) begin
      f_state_d = F_SYNC;
      err_d     = 1'b1;
      hold_d    = 1'b0;
`endif
    end
  end

  // Frame parser and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_state_q   <= F_SYNC;
      addr_q      <= '0;
      rem_q       <= 9'd0;
      chk_q       <= 8'd0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      hold_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      f_state_q   <= f_state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      chk_q       <= chk_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hold_q      <= hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

`ifdef PROG_LOADER_TIMEOUT_EN
  // Idle counter that aborts a frame stalled mid-transfer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_q <= 20'd0;
    end else begin
      idle_q <= idle_d;
    end
  end
`endif

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_prog_loader
// Description : Scoreboard bench for prog_loader. Stimulus pushes expected
//               writes and done pulses; a monitor pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

  localparam int CLK_DIV = 16;
  localparam int ADDR_W  = 12;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rxd = 1'b1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [11:0] exp_a[$];
  logic [7:0]  exp_d[$];
  int          done_pending = 0;

  prog_loader #(.CLK_DIV(CLK_DIV), .ADDR_W(ADDR_W)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rxd       (rxd),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  // Monitor: every write strobe and done pulse must match a queued expectation
  always @(negedge clk) begin
    if (rst_n && mem_we) begin
      if (exp_a.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", mem_addr, mem_wdata);
      end else begin
        logic [11:0] a;
        logic [7:0]  d;
        a = exp_a.pop_front();
        d = exp_d.pop_front();
        check("write_addr_data", {12'd0, mem_addr, mem_wdata}, {12'd0, a, d});
      end
    end
    if (rst_n && done) begin
      if (done_pending == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1, required done=0");
      end else begin
        done_pending--;
        n_checks++;
        n_pass++;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    repeat (CLK_DIV) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CLK_DIV) @(posedge clk);
    end
    rxd = stop;
    repeat (CLK_DIV) @(posedge clk);
    rxd = 1'b1;
    repeat (CLK_DIV) @(posedge clk);
  endtask

  // Sends a full frame of n bytes (dat[7:0] first); bad_chk corrupts CHK
  task automatic send_frame(input logic [11:0] a, input int n, input logic [31:0] dat,
                            input logic bad_chk);
    logic [7:0]  chk;
    logic [7:0]  b;
    logic [11:0] wa;
    chk = {4'h0, a[11:8]} ^ a[7:0] ^ 8'(n);
    wa  = a;
    for (int i = 0; i < n; i++) begin
      b   = dat[8*i +: 8];
      chk = chk ^ b;
      exp_a.push_back(wa);
      exp_d.push_back(b);
      wa  = wa + 12'd1;
    end
    if (!bad_chk) done_pending++;
    send_byte(8'hA5, 1'b1);
    @(negedge clk);
    check("hold_after_sync", {31'd0, cpu_hold}, 32'd1);
    check("err_cleared_by_sync", {31'd0, err}, 32'd0);
    send_byte({4'h0, a[11:8]}, 1'b1);
    send_byte(a[7:0], 1'b1);
    send_byte(8'(n), 1'b1);
    for (int i = 0; i < n; i++) send_byte(dat[8*i +: 8], 1'b1);
    @(negedge clk);
    check("hold_before_chk", {31'd0, cpu_hold}, 32'd1);
    send_byte(bad_chk ? ~chk : chk, 1'b1);
    @(negedge clk);
    check("hold_after_chk", {31'd0, cpu_hold}, 32'd0);
    check("err_after_chk", {31'd0, err}, {31'd0, bad_chk});
    check("writes_drained", 32'(exp_a.size()), 32'd0);
    check("done_drained", 32'(done_pending), 32'd0);
  endtask

  // Hard bound on run time
  initial begin
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  initial begin
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {12'd0, mem_we, mem_addr, mem_wdata, cpu_hold, done, err},
          32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);

    // Glitch and noise bytes: nothing happens
    rxd = 1'b0;
    repeat (3) @(posedge clk);
    rxd = 1'b1;
    repeat (2 * CLK_DIV) @(posedge clk);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h5A, 1'b1);
    @(negedge clk);
    check("noise_hold", {31'd0, cpu_hold}, 32'd0);
    check("noise_err", {31'd0, err}, 32'd0);

    // Good frame
    send_frame(12'h120, 2, 32'h0000_C33C, 1'b0);
    // Bad checksum, then a good frame whose SYNC clears err
    send_frame(12'h120, 2, 32'h0000_C33C, 1'b1);
    send_frame(12'h120, 2, 32'h0000_C33C, 1'b0);
    // Address wrap
    send_frame(12'hFFF, 2, 32'h0000_2211, 1'b0);

    // Framing error on ADDR_LO
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b0);
    @(negedge clk);
    check("ferr_err", {31'd0, err}, 32'd1);
    check("ferr_hold", {31'd0, cpu_hold}, 32'd0);
    // Recovery frame carrying 0xA5 as data
    send_frame(12'h345, 3, 32'h00A5_5A01, 1'b0);

    // Reset mid-frame after LEN
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h02, 1'b1);
    @(posedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midframe_reset_outputs",
          {12'd0, mem_we, mem_addr, mem_wdata, cpu_hold, done, err}, 32'd0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    send_frame(12'h0AB, 1, 32'h0000_0077, 1'b0);

`ifdef PROG_LOADER_TIMEOUT_EN
    // Stalled frame after ADDR_LO is aborted by the idle timeout
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h20, 1'b1);
    repeat (1000) @(posedge clk);
    @(negedge clk);
    check("stall_hold", {31'd0, cpu_hold}, 32'd1);
    repeat (160 * CLK_DIV) @(posedge clk);
    @(negedge clk);
    check("timeout_err", {31'd0, err}, 32'd1);
    check("timeout_hold", {31'd0, cpu_hold}, 32'd0);
`endif

    repeat (2 * CLK_DIV) @(posedge clk);
    @(negedge clk);
    check("final_writes_empty", 32'(exp_a.size()), 32'd0);
    check("final_done_empty", 32'(done_pending), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
